// File: rtl/ddr3_avl_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port DDR3 Avalon-MM
// local interface. The granted command is registered onto the avl_* bus, and
// a small ID FIFO routes in-order read data back to the requester that issued it.
module ddr3_avl_arbiter #(
  parameter int ADDR_WIDTH    = 24,
  parameter int DATA_WIDTH    = 64,
  parameter int RD_FIFO_DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  // requester 0
  input  logic                    r0_valid_i,
  output logic                    r0_ready_o,
  input  logic                    r0_write_i,
  input  logic [ADDR_WIDTH-1:0]   r0_addr_i,
  input  logic [DATA_WIDTH-1:0]   r0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] r0_be_i,
  output logic [DATA_WIDTH-1:0]   r0_rdata_o,
  output logic                    r0_rdata_valid_o,
  // requester 1
  input  logic                    r1_valid_i,
  output logic                    r1_ready_o,
  input  logic                    r1_write_i,
  input  logic [ADDR_WIDTH-1:0]   r1_addr_i,
  input  logic [DATA_WIDTH-1:0]   r1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] r1_be_i,
  output logic [DATA_WIDTH-1:0]   r1_rdata_o,
  output logic                    r1_rdata_valid_o,
  // controller local interface
  input  logic                    avl_ready_i,
  output logic                    avl_burstbegin_o,
  output logic [ADDR_WIDTH-1:0]   avl_addr_o,
  output logic [DATA_WIDTH-1:0]   avl_wdata_o,
  output logic [DATA_WIDTH/8-1:0] avl_be_o,
  output logic                    avl_read_req_o,
  output logic                    avl_write_req_o,
  output logic [6:0]              avl_size_o,
  input  logic [DATA_WIDTH-1:0]   avl_rdata_i,
  input  logic                    avl_rdata_valid_i,
  // status
  output logic                    err_unexpected_rdata_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W    = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
  localparam int CNT_W    = PTR_W + 1;

  // Registered command bus
  logic                  avl_read_req_q, avl_read_req_d;
  logic                  avl_write_req_q, avl_write_req_d;
  logic                  avl_burstbegin_q, avl_burstbegin_d;
  logic [ADDR_WIDTH-1:0] avl_addr_q, avl_addr_d;
  logic [DATA_WIDTH-1:0] avl_wdata_q, avl_wdata_d;
  logic [BE_WIDTH-1:0]   avl_be_q, avl_be_d;
  logic                  last_grant_q, last_grant_d;
  logic                  err_q, err_d;

  // Read-ID FIFO state
  logic                  id_mem [RD_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      rd_count_q, rd_count_d;

  logic pending, slot_free, pop, push, rd_room;
  logic elig0, elig1, grant0, grant1, any_grant, sel_write;
  logic head_id;

  // Arbitration: eligibility, round-robin grant and FIFO push/pop strobes
  always_comb begin
    pending   = avl_read_req_q | avl_write_req_q;
    slot_free = !pending | avl_ready_i;
    pop       = avl_rdata_valid_i & (rd_count_q != '0);
    // A read returning this cycle frees a slot, so a full FIFO can still take
    // a new read tag on the same edge (pointers both advance, count holds).
    rd_room   = (rd_count_q < CNT_W'(RD_FIFO_DEPTH)) | pop;
    elig0     = r0_valid_i & (r0_write_i | rd_room);
    elig1     = r1_valid_i & (r1_write_i | rd_room);
    // last_grant_q == 1 means r1 went last, so r0 wins a tie.
    grant0    = slot_free & elig0 & (!elig1 | last_grant_q);
    grant1    = slot_free & elig1 & (!elig0 | !last_grant_q);
    any_grant = grant0 | grant1;
    sel_write = grant1 ? r1_write_i : r0_write_i;
    push      = any_grant & !sel_write;
    head_id   = id_mem[rd_ptr_q];
  end

  assign r0_ready_o       = grant0;
  assign r1_ready_o       = grant1;
  assign r0_rdata_o       = avl_rdata_i;
  assign r1_rdata_o       = avl_rdata_i;
  assign r0_rdata_valid_o = pop & !head_id;
  assign r1_rdata_valid_o = pop & head_id;

  assign avl_read_req_o         = avl_read_req_q;
  assign avl_write_req_o        = avl_write_req_q;
  assign avl_burstbegin_o       = avl_burstbegin_q;
  assign avl_addr_o             = avl_addr_q;
  assign avl_wdata_o            = avl_wdata_q;
  assign avl_be_o               = avl_be_q;
  assign avl_size_o             = 7'h1;
  assign err_unexpected_rdata_o = err_q;

  // Next-state for the command register, FIFO pointers and error flag
  always_comb begin
    avl_read_req_d   = avl_read_req_q;
    avl_write_req_d  = avl_write_req_q;
    avl_burstbegin_d = 1'b0;   // only the first presented cycle carries it
    avl_addr_d       = avl_addr_q;
    avl_wdata_d      = avl_wdata_q;
    avl_be_d         = avl_be_q;
    last_grant_d     = last_grant_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    rd_count_d       = rd_count_q;
    err_d            = err_q | (avl_rdata_valid_i & (rd_count_q == '0));

    if (any_grant) begin
      avl_addr_d       = grant1 ? r1_addr_i  : r0_addr_i;
      avl_wdata_d      = grant1 ? r1_wdata_i : r0_wdata_i;
      avl_be_d         = grant1 ? r1_be_i    : r0_be_i;
      avl_write_req_d  = sel_write;
      avl_read_req_d   = !sel_write;
      avl_burstbegin_d = 1'b1;
      last_grant_d     = grant1;
    end else if (pending & avl_ready_i) begin
      avl_write_req_d  = 1'b0;
      avl_read_req_d   = 1'b0;
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   rd_count_d = rd_count_q + CNT_W'(1);
      2'b01:   rd_count_d = rd_count_q - CNT_W'(1);
      default: rd_count_d = rd_count_q;
    endcase
  end

  // State registers with synchronous reset; reset drops the pending command and all tags
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      avl_read_req_q   <= 1'b0;
      avl_write_req_q  <= 1'b0;
      avl_burstbegin_q <= 1'b0;
      avl_addr_q       <= '0;
      avl_wdata_q      <= '0;
      avl_be_q         <= '0;
      last_grant_q     <= 1'b1;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      rd_count_q       <= '0;
      err_q            <= 1'b0;
    end else begin
      avl_read_req_q   <= avl_read_req_d;
      avl_write_req_q  <= avl_write_req_d;
      avl_burstbegin_q <= avl_burstbegin_d;
      avl_addr_q       <= avl_addr_d;
      avl_wdata_q      <= avl_wdata_d;
      avl_be_q         <= avl_be_d;
      last_grant_q     <= last_grant_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      rd_count_q       <= rd_count_d;
      err_q            <= err_d;
    end
  end

  // Requester-ID storage; read combinationally at the head so data routes in the return cycle
  always_ff @(posedge clk_i) begin
    if (!reset_i && push) id_mem[wr_ptr_q] <= grant1;
  end

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Directed bench for ddr3_avl_arbiter: a vector table for handshake/hold
// behaviour plus hand-written sequences for reads, back-pressure and reset.
module tb_ddr3_avl_arbiter;

  localparam int AW = 24;
  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam logic [DW-1:0] W0 = 64'hdeadfadebabebeef;
  localparam logic [DW-1:0] W1 = 64'h0123456789abcdef;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          r0_valid_i, r0_ready_o, r0_write_i, r0_rdata_valid_o;
  logic [AW-1:0] r0_addr_i;
  logic [DW-1:0] r0_wdata_i, r0_rdata_o;
  logic [BW-1:0] r0_be_i;
  logic          r1_valid_i, r1_ready_o, r1_write_i, r1_rdata_valid_o;
  logic [AW-1:0] r1_addr_i;
  logic [DW-1:0] r1_wdata_i, r1_rdata_o;
  logic [BW-1:0] r1_be_i;
  logic          avl_ready_i, avl_burstbegin_o, avl_read_req_o, avl_write_req_o;
  logic [AW-1:0] avl_addr_o;
  logic [DW-1:0] avl_wdata_o, avl_rdata_i;
  logic [BW-1:0] avl_be_o;
  logic [6:0]    avl_size_o;
  logic          avl_rdata_valid_i, err_unexpected_rdata_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ddr3_avl_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_FIFO_DEPTH(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .r0_valid_i(r0_valid_i), .r0_ready_o(r0_ready_o), .r0_write_i(r0_write_i),
    .r0_addr_i(r0_addr_i), .r0_wdata_i(r0_wdata_i), .r0_be_i(r0_be_i),
    .r0_rdata_o(r0_rdata_o), .r0_rdata_valid_o(r0_rdata_valid_o),
    .r1_valid_i(r1_valid_i), .r1_ready_o(r1_ready_o), .r1_write_i(r1_write_i),
    .r1_addr_i(r1_addr_i), .r1_wdata_i(r1_wdata_i), .r1_be_i(r1_be_i),
    .r1_rdata_o(r1_rdata_o), .r1_rdata_valid_o(r1_rdata_valid_o),
    .avl_ready_i(avl_ready_i), .avl_burstbegin_o(avl_burstbegin_o),
    .avl_addr_o(avl_addr_o), .avl_wdata_o(avl_wdata_o), .avl_be_o(avl_be_o),
    .avl_read_req_o(avl_read_req_o), .avl_write_req_o(avl_write_req_o),
    .avl_size_o(avl_size_o), .avl_rdata_i(avl_rdata_i),
    .avl_rdata_valid_i(avl_rdata_valid_i),
    .err_unexpected_rdata_o(err_unexpected_rdata_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          v0, w0;
    logic [AW-1:0] a0;
    logic          v1, w1;
    logic [AW-1:0] a1;
    logic          ardy;
    logic          e_rdy0, e_rdy1, e_rd, e_wr, e_bb;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_be;
    logic [DW-1:0] e_wdata;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic v0, input logic w0, input logic [AW-1:0] a0,
                              input logic v1, input logic w1, input logic [AW-1:0] a1,
                              input logic ardy, input logic e_rdy0, input logic e_rdy1,
                              input logic e_rd, input logic e_wr, input logic e_bb,
                              input logic [AW-1:0] e_addr, input logic [BW-1:0] e_be,
                              input logic [DW-1:0] e_wdata);
    vec_t v;
    v.v0 = v0; v.w0 = w0; v.a0 = a0; v.v1 = v1; v.w1 = w1; v.a1 = a1; v.ardy = ardy;
    v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_rd = e_rd; v.e_wr = e_wr; v.e_bb = e_bb;
    v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    r0_valid_i = 1'b0; r0_write_i = 1'b0; r0_addr_i = '0;
    r1_valid_i = 1'b0; r1_write_i = 1'b0; r1_addr_i = '0;
    avl_ready_i = 1'b1; avl_rdata_valid_i = 1'b0; avl_rdata_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rdv [4];
    rdv[0] = 64'hA0; rdv[1] = 64'hB1; rdv[2] = 64'hA2; rdv[3] = 64'hB3;

    r0_wdata_i = W0; r0_be_i = 8'hff;
    r1_wdata_i = W1; r1_be_i = 8'h0f;
    idle_inputs();
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;

    // reset state
    @(negedge clk_i);
    chk("rst read_req", avl_read_req_o, 0);
    chk("rst write_req", avl_write_req_o, 0);
    chk("rst burstbegin", avl_burstbegin_o, 0);
    chk("rst addr", avl_addr_o, 0);
    chk("rst be", avl_be_o, 0);
    chk("rst size", avl_size_o, 1);
    chk("rst err", err_unexpected_rdata_o, 0);
    tick();

    // Table: single write, back-pressure hold, tie-break and alternation
    //            v0 w0 a0     v1 w1 a1     rdy  r0 r1 rd wr bb addr    be     wdata
    tbl[0]  = mk(1, 1, 24'h10, 0, 0, 24'h0,  1,   1, 0, 0, 0, 0, 24'h0,  8'h00, '0);
    tbl[1]  = mk(0, 0, 24'h0,  0, 0, 24'h0,  1,   0, 0, 0, 1, 1, 24'h10, 8'hff, W0);
    tbl[2]  = mk(0, 0, 24'h0,  0, 0, 24'h0,  1,   0, 0, 0, 0, 0, 24'h10, 8'hff, W0);
    tbl[3]  = mk(0, 0, 24'h0,  1, 0, 24'h20, 0,   0, 1, 0, 0, 0, 24'h10, 8'hff, W0);
    tbl[4]  = mk(1, 1, 24'h30, 1, 0, 24'h21, 0,   0, 0, 1, 0, 1, 24'h20, 8'h0f, W1);
    tbl[5]  = mk(1, 1, 24'h30, 1, 0, 24'h21, 0,   0, 0, 1, 0, 0, 24'h20, 8'h0f, W1);
    tbl[6]  = mk(1, 1, 24'h30, 1, 0, 24'h21, 0,   0, 0, 1, 0, 0, 24'h20, 8'h0f, W1);
    tbl[7]  = mk(1, 1, 24'h30, 1, 0, 24'h21, 0,   0, 0, 1, 0, 0, 24'h20, 8'h0f, W1);
    tbl[8]  = mk(1, 1, 24'h30, 1, 0, 24'h21, 1,   1, 0, 1, 0, 0, 24'h20, 8'h0f, W1);
    tbl[9]  = mk(0, 0, 24'h0,  1, 0, 24'h21, 1,   0, 1, 0, 1, 1, 24'h30, 8'hff, W0);
    tbl[10] = mk(0, 0, 24'h0,  0, 0, 24'h0,  1,   0, 0, 1, 0, 1, 24'h21, 8'h0f, W1);
    tbl[11] = mk(0, 0, 24'h0,  0, 0, 24'h0,  1,   0, 0, 0, 0, 0, 24'h21, 8'h0f, W1);

    for (int i = 0; i < 12; i++) begin
      r0_valid_i = tbl[i].v0; r0_write_i = tbl[i].w0; r0_addr_i = tbl[i].a0;
      r1_valid_i = tbl[i].v1; r1_write_i = tbl[i].w1; r1_addr_i = tbl[i].a1;
      avl_ready_i = tbl[i].ardy;
      @(negedge clk_i);
      chk($sformatf("vec%0d r0_ready", i), r0_ready_o, tbl[i].e_rdy0);
      chk($sformatf("vec%0d r1_ready", i), r1_ready_o, tbl[i].e_rdy1);
      chk($sformatf("vec%0d read_req", i), avl_read_req_o, tbl[i].e_rd);
      chk($sformatf("vec%0d write_req", i), avl_write_req_o, tbl[i].e_wr);
      chk($sformatf("vec%0d burstbegin", i), avl_burstbegin_o, tbl[i].e_bb);
      chk($sformatf("vec%0d addr", i), avl_addr_o, tbl[i].e_addr);
      chk($sformatf("vec%0d be", i), avl_be_o, tbl[i].e_be);
      chk($sformatf("vec%0d wdata", i), avl_wdata_o, tbl[i].e_wdata);
      $display("vec%0d applied", i);
      tick();
    end

    // Alternating reads with in-order returns routed to the issuing requester
    do_reset();
    for (int c = 0; c < 9; c++) begin
      r0_valid_i = (c < 4); r0_write_i = 1'b0; r0_addr_i = 24'h100;
      r1_valid_i = (c < 4); r1_write_i = 1'b0; r1_addr_i = 24'h200;
      avl_ready_i = 1'b1;
      avl_rdata_valid_i = (c >= 4 && c <= 7);
      avl_rdata_i = (c >= 4 && c <= 7) ? rdv[c-4] : '0;
      @(negedge clk_i);
      chk($sformatf("rr c%0d r0_ready", c), r0_ready_o, (c < 4) && (c % 2 == 0));
      chk($sformatf("rr c%0d r1_ready", c), r1_ready_o, (c < 4) && (c % 2 == 1));
      if (c >= 1 && c <= 4)
        chk($sformatf("rr c%0d addr", c), avl_addr_o, (c % 2 == 1) ? 24'h100 : 24'h200);
      chk($sformatf("rr c%0d read_req", c), avl_read_req_o, (c >= 1 && c <= 4));
      chk($sformatf("rr c%0d r0_rvalid", c), r0_rdata_valid_o, (c == 4 || c == 6));
      chk($sformatf("rr c%0d r1_rvalid", c), r1_rdata_valid_o, (c == 5 || c == 7));
      if (c == 4 || c == 6) chk($sformatf("rr c%0d r0_rdata", c), r0_rdata_o, rdv[c-4]);
      if (c == 5 || c == 7) chk($sformatf("rr c%0d r1_rdata", c), r1_rdata_o, rdv[c-4]);
      $display("rr cycle %0d", c);
      tick();
    end
    chk("rr err", err_unexpected_rdata_o, 0);

    // Read FIFO full: reads stall, writes pass, a return frees a same-cycle grant
    do_reset();
    for (int c = 0; c < 23; c++) begin
      r0_valid_i = (c <= 10); r0_write_i = 1'b0;
      r0_addr_i = (c < 8) ? 24'(24'h300 + c) : 24'h308;
      r1_valid_i = (c == 8); r1_write_i = 1'b1; r1_addr_i = 24'h400;
      avl_ready_i = 1'b1;
      avl_rdata_valid_i = (c >= 10 && c <= 19);
      avl_rdata_i = 64'(64'hC0 + c);
      @(negedge clk_i);
      if (c < 8)  chk($sformatf("full c%0d r0_ready", c), r0_ready_o, 1);
      if (c == 8) begin
        chk("full c8 r0_ready", r0_ready_o, 0);
        chk("full c8 r1_ready", r1_ready_o, 1);
      end
      if (c == 9) begin
        chk("full c9 r0_ready", r0_ready_o, 0);
        chk("full c9 write_req", avl_write_req_o, 1);
        chk("full c9 addr", avl_addr_o, 24'h400);
      end
      if (c == 10) chk("full c10 r0_ready", r0_ready_o, 1);
      if (c >= 10 && c <= 18) begin
        chk($sformatf("full c%0d r0_rvalid", c), r0_rdata_valid_o, 1);
        chk($sformatf("full c%0d r1_rvalid", c), r1_rdata_valid_o, 0);
      end
      if (c == 11) begin
        chk("full c11 read_req", avl_read_req_o, 1);
        chk("full c11 addr", avl_addr_o, 24'h308);
      end
      if (c == 19) begin
        chk("unexp c19 r0_rvalid", r0_rdata_valid_o, 0);
        chk("unexp c19 r1_rvalid", r1_rdata_valid_o, 0);
        chk("unexp c19 err", err_unexpected_rdata_o, 0);
      end
      if (c >= 20) chk($sformatf("unexp c%0d err sticky", c), err_unexpected_rdata_o, 1);
      $display("full cycle %0d", c);
      tick();
    end
    do_reset();
    @(negedge clk_i);
    chk("err cleared by reset", err_unexpected_rdata_o, 0);
    tick();

    // Reset with reads outstanding and a command held pending
    for (int c = 0; c < 4; c++) begin
      r0_valid_i = (c < 3); r0_write_i = 1'b0; r0_addr_i = 24'(24'h500 + c);
      avl_ready_i = (c < 3);
      @(negedge clk_i);
      if (c < 3) chk($sformatf("rst6 c%0d r0_ready", c), r0_ready_o, 1);
      else       chk("rst6 c3 pending", avl_read_req_o, 1);
      tick();
    end
    do_reset();
    avl_rdata_valid_i = 1'b1; avl_rdata_i = 64'h77;
    @(negedge clk_i);
    chk("rst6 read_req", avl_read_req_o, 0);
    chk("rst6 write_req", avl_write_req_o, 0);
    chk("rst6 burstbegin", avl_burstbegin_o, 0);
    chk("rst6 addr", avl_addr_o, 0);
    chk("rst6 r0_rvalid", r0_rdata_valid_o, 0);
    chk("rst6 r1_rvalid", r1_rdata_valid_o, 0);
    tick();
    avl_rdata_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rst6 err", err_unexpected_rdata_o, 1);
    $display("reset-with-outstanding sequence done");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
